// File: rtl/lut_logic_array_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : lut_logic_array_if                                         |
// | Purpose   : Config, input-beat, result-beat and status signals of the  |
// |             lookup-table logic array, grouped with master/slave views. |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface lut_logic_array_if #(
  parameter int K     = 2,
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  localparam int ONES_W = $clog2(LANES + 1);

  logic                 cfg_we;
  logic [2**K-1:0]      cfg_func;
  logic [2**K-1:0]      func;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*K-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES-1:0]     out_data;
  logic [ONES_W-1:0]    out_ones;
  logic [CNT_W-1:0]     beat_cnt;

  // Producer/consumer side
  modport master (
    output cfg_we, cfg_func, in_valid, in_data, out_ready,
    input  func, in_ready, out_valid, out_data, out_ones, beat_cnt
  );

  // Logic array side
  modport slave (
    input  cfg_we, cfg_func, in_valid, in_data, out_ready,
    output func, in_ready, out_valid, out_data, out_ones, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lut_logic_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : lut_logic_array                                             |
// | Purpose  : LANES parallel K-input lookup functions sharing one         |
// |            run-time loadable truth table, registered behind a          |
// |            valid/ready stage with per-beat popcount and beat counter.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module lut_logic_array #(
  parameter int              K        = 2,
  parameter int              LANES    = 4,
  parameter logic [2**K-1:0] FUNC_RST = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  lut_logic_array_if.slave   bus
);
  localparam int ONES_W = $clog2(LANES + 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2**K-1:0]    func_q, func_d;
  logic [LANES-1:0]   data_q, data_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LANES-1:0]   lane_res;
  logic [ONES_W-1:0]  lane_ones;
  logic               out_valid;
  logic               in_ready;
  logic               accept;
  logic               deliver;

  // Each lane uses its K-bit operand as an index into the current table
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_res[j] = func_q[bus.in_data[j*K +: K]];
  end

  // Popcount of the incoming beat, registered alongside the lane results
  always_comb begin
    lane_ones = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_ones = lane_ones + ONES_W'(lane_res[j]);
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign in_ready  = !out_valid || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign deliver   = out_valid && bus.out_ready;

  // Next-state: output stage occupancy, result capture, counter and table load
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (deliver && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    // Capture uses func_q, so a beat accepted alongside cfg_we sees the old table
    if (accept) begin
      data_d = lane_res;
      ones_d = lane_ones;
    end
    if (deliver) cnt_d = cnt_q + CNT_W'(1);
    if (bus.cfg_we) func_d = bus.cfg_func;
  end

  // State register; reset discards any held beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      func_q  <= FUNC_RST;
      data_q  <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      data_q  <= data_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_ones  = ones_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.func      = func_q;
endmodule
`default_nettype wire

// File: tb/tb_lut_logic_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_lut_logic_array                                          |
// | Purpose  : Directed-vector bench for lut_logic_array with a queue      |
// |            scoreboard and an independent output monitor.              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_lut_logic_array;
  localparam int       K        = 2;
  localparam int       LANES    = 4;
  localparam int       CNT_W    = 4;
  localparam logic [3:0] FUNC_RST = 4'b1001;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_cnt;
  logic [6:0] sb_q[$];   // {out_data, out_ones}

  lut_logic_array_if #(.K(K), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  lut_logic_array #(
    .K(K), .LANES(LANES), .FUNC_RST(FUNC_RST), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per delivered beat; reset flushes everything
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data %0d with no beat expected at %0t",
                 bus.out_data, $time);
      end else begin
        logic [6:0] e;
        e = sb_q.pop_front();
        chk("out_data", int'(bus.out_data), int'(e[6:3]));
        chk("out_ones", int'(bus.out_ones), int'(e[2:0]));
        chk("beat_cnt_pre", int'(bus.beat_cnt), exp_cnt);
      end
      exp_cnt = (exp_cnt + 1) % 16;
    end
  end

  // Present one beat, wait (bounded) for acceptance, record its expected result
  task automatic send(input logic [7:0] d, input logic [3:0] ed, input logic [2:0] eo);
    int waits;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back({ed, eo});
        break;
      end
      waits++;
      if (waits > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic load_func(input logic [3:0] f);
    bus.cfg_we   = 1'b1;
    bus.cfg_func = f;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  logic [7:0] st_d [8] = '{8'hFF, 8'h00, 8'h0F, 8'hF0, 8'hC3, 8'h3C, 8'hFC, 8'h7F};
  logic [3:0] st_e [8] = '{4'b1111, 4'b0000, 4'b0011, 4'b1100,
                           4'b1001, 4'b0110, 4'b1110, 4'b0111};
  logic [2:0] st_o [8] = '{3'd4, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3};

  initial begin
    total = 0; bad = 0; exp_cnt = 0;
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_func = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data), 0);
    chk("rst_out_ones",  int'(bus.out_ones), 0);
    chk("rst_beat_cnt",  int'(bus.beat_cnt), 0);
    chk("rst_func",      int'(bus.func), int'(FUNC_RST));
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    rst_n = 1'b1;

    // 1: XOR on all four operand combinations, 1-cycle latency
    load_func(4'b0110);
    chk("t1_func", int'(bus.func), 6);
    bus.out_ready = 1'b1;
    send(8'b00_01_10_11, 4'b0110, 3'd2);
    chk("t1_latency_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk("t1_beat_cnt", int'(bus.beat_cnt), 1);
    chk("t1_empty_after", int'(bus.out_valid), 0);

    // 2: backpressure holds the beat, then deliver+accept in one cycle
    bus.out_ready = 1'b0;
    send(8'h1B, 4'b0110, 3'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;                  // every lane 2'b10 -> XOR gives 1
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_in_ready_stall", int'(bus.in_ready), 0);
      chk("t2_hold_data", int'(bus.out_data), 6);
      chk("t2_hold_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    chk("t2_cnt_during_stall", int'(bus.beat_cnt), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_in_ready_release", int'(bus.in_ready), 1);
    sb_q.push_back({4'b1111, 3'd4});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t2_cnt_plus_one", int'(bus.beat_cnt), 2);
    chk("t2_next_beat_held", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk("t2_cnt_final", int'(bus.beat_cnt), 3);

    // 3: streaming 8 beats through AND
    do_reset();
    load_func(4'b1000);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) chk("t3_valid_continuous", int'(bus.out_valid), 1);
      send(st_d[i], st_e[i], st_o[i]);
    end
    @(posedge clk); #1;
    chk("t3_beat_cnt", int'(bus.beat_cnt), 8);

    // 4: table load racing an accepted beat
    bus.cfg_we   = 1'b1;
    bus.cfg_func = 4'b1110;
    send(8'hFF, 4'b1111, 3'd4);            // old AND table
    bus.cfg_we   = 1'b0;
    // 8'h11: lanes j0=01,j1=00,j2=01,j3=00 under OR -> 4'b0101
    send(8'h11, 4'b0101, 3'd2);
    @(posedge clk); #1;
    chk("t4_func_or", int'(bus.func), 14);

    // 5: reset while a beat is stalled in the output register
    bus.out_ready = 1'b0;
    send(8'h55, 4'b1111, 3'd4);
    chk("t5_full", int'(bus.out_valid), 1);
    do_reset();
    chk("t5_out_valid", int'(bus.out_valid), 0);
    chk("t5_beat_cnt", int'(bus.beat_cnt), 0);
    chk("t5_func", int'(bus.func), int'(FUNC_RST));
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_beat_gone", int'(bus.out_valid), 0);

    // 6: 4-bit counter wrap over 17 beats (FUNC_RST maps 2'b00 -> 1)
    for (int i = 1; i <= 17; i++) begin
      send(8'h00, 4'b1111, 3'd4);
      if (i == 16) chk("t6_cnt_15", int'(bus.beat_cnt), 15);
      if (i == 17) chk("t6_cnt_0", int'(bus.beat_cnt), 0);
    end
    @(posedge clk); #1;
    chk("t6_cnt_1", int'(bus.beat_cnt), 1);

    // Drain
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
